alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit_pkg.sv | 19 +
 rtl/alu_exec_unit_if.sv | 33 +++
 rtl/alu_exec_unit_mul_iter.sv | 82 ++++++++
 rtl/alu_exec_unit.sv | 148 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execution unit.
//   - Opcode encodings accepted on the request channel (ADD, SUB, MUL).
//   - FSM state encoding used by alu_exec_unit.
// Any other opcode value is reported as illegal through the err flag.
package alu_exec_unit_pkg;

  localparam int OP_W = 7;

  localparam logic [OP_W-1:0] ADD = 7'h00;
  localparam logic [OP_W-1:0] SUB = 7'h01;
  localparam logic [OP_W-1:0] MUL = 7'h02;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between an issue source and alu_exec_unit.
//   Request : in_valid, in_ready, op, x, y
//   Response: out_valid, out_ready, w, ovf, err
// master = issue side (drives request, consumes response)
// slave  = execution unit (accepts request, produces response)
interface alu_exec_unit_if
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] w;
  logic              ovf;
  logic              err;

  modport master (
    output in_valid, op, x, y, out_ready,
    input  in_ready, out_valid, w, ovf, err
  );

  modport slave (
    input  in_valid, op, x, y, out_ready,
    output in_ready, out_valid, w, ovf, err
  );

endinterface

// File: rtl/alu_exec_unit_mul_iter.sv
// Iterative unsigned shift-add multiplier.
//   clk, rst : clock, synchronous active-high reset
//   start    : load mag_a/mag_b and begin a new multiplication
//   mag_a/b  : unsigned DATA_W-bit operands
//   done     : high in the cycle the final step is being applied
//   product  : 2*DATA_W-bit product, valid while done is high
// One partial product is added per cycle over DATA_W cycles. The product
// port exposes the accumulator value after the current step, so the owner
// can register the finished result in the same edge the last step runs.
module mul_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     mag_a,
  input  logic [DATA_W-1:0]     mag_b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  logic                busy_q,   busy_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [2*DATA_W-1:0] acc_q,    acc_d;
  logic [2*DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;

  logic [2*DATA_W-1:0] step_acc;

  always_comb begin
    // Multiplicand shifts left while the multiplier shifts right, so the
    // current multiplier LSB always selects the correctly weighted addend.
    step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{DATA_W{1'b0}}, mag_a};
      mplier_d = mag_b;
    end else if (busy_q) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == LAST_STEP) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign done    = busy_q && (cnt_q == LAST_STEP);
  assign product = step_acc;

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of alu_exec_unit_if
//              request  in_valid/in_ready + op, x, y
//              response out_valid/out_ready + w, ovf, err
// ADD/SUB and illegal opcodes complete in one cycle; MUL runs through the
// iterative multiplier over DATA_W cycles on operand magnitudes, with the
// sign restored afterwards. Only one operation is in flight: a new request
// is accepted only after the previous result has been taken.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);

  localparam int MSB = DATA_W - 1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] w_q,     w_d;
  logic              ovf_q,   ovf_d;
  logic              err_q,   err_d;
  logic              neg_q,   neg_d;

  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;

  logic [DATA_W-1:0]   sum, diff;
  logic                add_ovf, sub_ovf;
  logic [DATA_W-1:0]   mag_x, mag_y;
  logic [2*DATA_W-1:0] prod_signed;
  logic [DATA_W:0]     prod_high;
  logic                mul_ovf;

  // Datapath decodes from the live request operands and the multiplier.
  // Magnitudes are taken as unsigned, so the most negative value maps to
  // 2^(DATA_W-1) without wrapping.
  always_comb begin
    sum         = bus.x + bus.y;
    diff        = bus.x - bus.y;
    add_ovf     = (bus.x[MSB] == bus.y[MSB]) && (sum[MSB]  != bus.x[MSB]);
    sub_ovf     = (bus.x[MSB] != bus.y[MSB]) && (diff[MSB] != bus.x[MSB]);
    mag_x       = bus.x[MSB] ? -bus.x : bus.x;
    mag_y       = bus.y[MSB] ? -bus.y : bus.y;
    prod_signed = neg_q ? -mul_product : mul_product;
    prod_high   = prod_signed[2*DATA_W-1:DATA_W-1];
    mul_ovf     = !((&prod_high) || !(|prod_high));
  end

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .mag_a   (mag_x),
    .mag_b   (mag_y),
    .done    (mul_done),
    .product (mul_product)
  );

  // Next-state and result-register logic. Result registers only change on
  // acceptance of a one-cycle op or on multiplier completion, which keeps
  // w/ovf/err stable for the whole DONE phase under back-pressure.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    neg_d     = neg_q;
    mul_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          case (bus.op)
            ADD: begin
              w_d     = sum;
              ovf_d   = add_ovf;
              err_d   = 1'b0;
              state_d = ST_DONE;
            end
            SUB: begin
              w_d     = diff;
              ovf_d   = sub_ovf;
              err_d   = 1'b0;
              state_d = ST_DONE;
            end
            MUL: begin
              mul_start = 1'b1;
              neg_d     = bus.x[MSB] ^ bus.y[MSB];
              err_d     = 1'b0;
              state_d   = ST_MUL_RUN;
            end
            default: begin
              w_d     = '0;
              ovf_d   = 1'b0;
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_MUL_RUN: begin
        if (mul_done) begin
          w_d     = prod_signed[DATA_W-1:0];
          ovf_d   = mul_ovf;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      neg_q   <= neg_d;
    end
  end

  // Handshake outputs are pure state decodes, so neither in_valid nor
  // out_ready reaches an output combinationally.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.w         = w_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
// Inputs are driven and outputs sampled on the falling clock edge, half a
// period away from the rising edge the DUT acts on. Latency is counted in
// falling edges after the accepting rising edge: 1 for ADD/SUB/illegal,
// DATA_W+1 for MUL.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  alu_exec_unit_if #(.DATA_W(DATA_W)) bus ();

  alu_exec_unit #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports any mismatch.
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request, let the next rising edge accept it, then drop
  // in_valid and scramble the operands to show they were captured.
  task automatic apply_stimulus(input logic [6:0] op, input logic [31:0] x,
                                input logic [31:0] y);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.x        = x;
    bus.y        = y;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x        = ~x;
    bus.y        = 32'h5A5A_5A5A;
  endtask

  // Full transaction with out_ready held high: checks acceptance, latency,
  // in_ready low while busy, the result fields and the return to idle.
  task automatic run_op(input string tag, input logic [6:0] op,
                        input logic [31:0] x, input logic [31:0] y,
                        input int exp_lat, input logic [31:0] exp_w,
                        input logic exp_ovf, input logic exp_err);
    int   lat;
    logic ready_seen;
    check_output({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    apply_stimulus(op, x, y);
    lat        = 1;
    ready_seen = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (bus.in_ready) ready_seen = 1'b1;
    check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, "_busy_ready"}, 32'(ready_seen), 32'd0);
    check_output({tag, "_w"}, bus.w, exp_w);
    check_output({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    check_output({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    @(posedge clk);
    @(negedge clk);
    check_output({tag, "_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
  endtask

  initial begin : stim
    logic seen_valid;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = ADD;
    bus.x         = '0;
    bus.y         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    check_output("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_w",         bus.w,              32'd0);
    check_output("rst_ovf",       32'(bus.ovf),       32'd0);
    check_output("rst_err",       32'(bus.err),       32'd0);

    $display("[TB] add/sub");
    run_op("add_small", ADD, 32'h0000_0001, 32'h0000_0002, 1, 32'h0000_0003, 1'b0, 1'b0);
    run_op("add_ovf",   ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h8000_0000, 1'b1, 1'b0);
    run_op("sub_neg",   SUB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   SUB, 32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 1'b1, 1'b0);

    $display("[TB] mul");
    run_op("mul_negneg", MUL, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 33, 32'h0000_0006, 1'b0, 1'b0);
    run_op("mul_pos",    MUL, 32'h0FFF_FFFF, 32'h0000_0002, 33, 32'h1FFF_FFFE, 1'b0, 1'b0);
    run_op("mul_minint", MUL, 32'h8000_0000, 32'hFFFF_FFFE, 33, 32'h0000_0000, 1'b1, 1'b0);
    run_op("mul_mixed",  MUL, 32'hFFFF_FFFF, 32'h0000_0005, 33, 32'hFFFF_FFFB, 1'b0, 1'b0);

    $display("[TB] back-pressure");
    bus.out_ready = 1'b0;
    check_output("bp_in_ready", 32'(bus.in_ready), 32'd1);
    apply_stimulus(ADD, 32'd3, 32'd4);
    bus.in_valid = 1'b1;
    bus.op       = SUB;
    bus.x        = 32'd10;
    bus.y        = 32'd2;
    for (int i = 0; i < 5; i++) begin
      check_output("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_output("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      check_output("bp_w", bus.w, 32'd7);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("bp_consumed", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_output("bp_held_valid", 32'(bus.out_valid), 32'd1);
    check_output("bp_held_w",     bus.w,              32'd8);
    check_output("bp_held_ovf",   32'(bus.ovf),       32'd0);
    @(posedge clk);
    @(negedge clk);
    check_output("bp_held_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);

    $display("[TB] reset during mul");
    apply_stimulus(MUL, 32'd5, 32'd7);
    repeat (9) @(negedge clk);
    check_output("rmul_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("rmul_in_ready",  32'(bus.in_ready),  32'd1);
    check_output("rmul_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rmul_w",         bus.w,              32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    check_output("rmul_no_pulse", 32'(seen_valid), 32'd0);

    $display("[TB] illegal op");
    run_op("illegal",   7'h7F, 32'h0000_1234, 32'h0000_5678, 1, 32'h0000_0000, 1'b0, 1'b1);
    run_op("add_wrap0", ADD,   32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
